sd_loader_cmd_arbiter: RTL and testbench

Shares the loader command channel to the Nios between two requesters: port A (ZX bus side) and port B (OSD/front panel). It arbitrates round-robin, presents the granted 8-bit command on cmd_byte to the Nios command PIO input, and raises an IRQ. The Nios completes each command by writing a result over a small Avalon-MM slave, and the result is returned to the originating requester. A watchdog aborts commands the Nios never completes.

---
 rtl/sd_loader_cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_sd_loader_cmd_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_loader_cmd_arbiter.sv
// Round-robin arbiter sharing the loader command channel between two requesters and the Nios.
// The Nios sees the granted command plus an IRQ and returns a result over a small Avalon slave.
module sd_loader_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0]  ERR_RESULT     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [7:0]  a_cmd,
  output logic        a_ack,
  output logic [7:0]  a_result,
  input  logic        b_req,
  input  logic [7:0]  b_cmd,
  output logic        b_ack,
  output logic [7:0]  b_result,
  output logic [7:0]  cmd_byte,
  output logic        irq,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  localparam logic [1:0] AddrCmd    = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrResult = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state;
  logic            src;
  logic            last_grant;
  logic            pending;
  logic            irq_en;
  logic            timeout_flag;
  logic            a_ign;
  logic            b_ign;
  logic [CntW-1:0] cnt;

  logic       a_eff, b_eff, grant_any, grant_b;
  logic       res_wr, ctrl_wr, expired, to_resp, timeout_hit;
  logic       pending_d, irq_en_d;
  logic [7:0] resp_val;
  logic       unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  always_comb begin
    // A requester acked last cycle may still hold req; that level is not a new request.
    a_eff       = a_req & ~a_ign;
    b_eff       = b_req & ~b_ign;
    grant_any   = a_eff | b_eff;
    grant_b     = b_eff & (~a_eff | ~last_grant);
    res_wr      = write && (address == AddrResult) && (state == StBusy);
    ctrl_wr     = write && (address == AddrCtrl);
    // The counter is cleared on entry, so the abort lands one cycle after it passes the limit - 1.
    expired     = (TIMEOUT_CYCLES != 0) && (cnt == CntMax);
    to_resp     = (state == StBusy) && (res_wr || expired);
    timeout_hit = (state == StBusy) && expired && !res_wr;
    resp_val    = res_wr ? writedata[7:0] : ERR_RESULT;
    pending_d   = ((state == StIdle) && grant_any) || ((state == StBusy) && !to_resp);
    irq_en_d    = ctrl_wr ? writedata[0] : irq_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      src          <= 1'b0;
      last_grant   <= 1'b1;
      pending      <= 1'b0;
      irq_en       <= 1'b1;
      timeout_flag <= 1'b0;
      a_ign        <= 1'b0;
      b_ign        <= 1'b0;
      cnt          <= '0;
      a_ack        <= 1'b0;
      a_result     <= 8'h00;
      b_ack        <= 1'b0;
      b_result     <= 8'h00;
      cmd_byte     <= 8'h00;
      irq          <= 1'b0;
      readdata     <= 32'h0;
    end else begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_ign   <= a_ack;
      b_ign   <= b_ack;
      pending <= pending_d;
      irq_en  <= irq_en_d;
      irq     <= pending_d & irq_en_d;

      if (ctrl_wr && writedata[1]) timeout_flag <= 1'b0;
      if (timeout_hit)             timeout_flag <= 1'b1;

      // Reads sample the registers before this cycle's write takes effect.
      readdata <= 32'h0;
      if (read) begin
        case (address)
          AddrCmd:    readdata <= {23'd0, src, cmd_byte};
          AddrStatus: readdata <= {30'd0, timeout_flag, pending};
          AddrCtrl:   readdata <= {31'd0, irq_en};
          default:    readdata <= 32'h0;
        endcase
      end

      case (state)
        StIdle: begin
          cnt <= '0;
          if (grant_any) begin
            state      <= StBusy;
            src        <= grant_b;
            last_grant <= grant_b;
            cmd_byte   <= grant_b ? b_cmd : a_cmd;
          end
        end
        StBusy: begin
          if (cnt != CntMax) cnt <= cnt + CntW'(1);
          if (to_resp) begin
            state    <= StResp;
            cmd_byte <= 8'h00;
            if (src) begin
              b_ack    <= 1'b1;
              b_result <= resp_val;
            end else begin
              a_ack    <= 1'b1;
              a_result <= resp_val;
            end
          end
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_loader_cmd_arbiter.sv
// Bench for sd_loader_cmd_arbiter: directed scenarios plus randomized requesters and Nios traffic,
// all outputs compared every cycle against a job-level reference model.
module tb_sd_loader_cmd_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [7:0]  a_cmd, b_cmd;
  logic        a_ack, b_ack;
  logic [7:0]  a_result, b_result;
  logic [7:0]  cmd_byte;
  logic        irq;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  sd_loader_cmd_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RESULT    (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_cmd    (a_cmd),
    .a_ack    (a_ack),
    .a_result (a_result),
    .b_req    (b_req),
    .b_cmd    (b_cmd),
    .b_ack    (b_ack),
    .b_result (b_result),
    .cmd_byte (cmd_byte),
    .irq      (irq),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: a job is either waiting, being serviced, or just answered.
  int          m_ph;  // 0 no job, 1 job with Nios, 2 answer cycle
  logic        m_src, m_last_b, m_ien, m_tflag;
  logic [7:0]  m_cmd, m_res_a, m_res_b, m_cmdb;
  int          m_age;
  logic        m_ack_a, m_ack_b, m_prev_ack_a, m_prev_ack_b, m_irq;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_ph = 0; m_src = 1'b0; m_last_b = 1'b1; m_ien = 1'b1; m_tflag = 1'b0;
    m_cmd = 8'h00; m_res_a = 8'h00; m_res_b = 8'h00; m_cmdb = 8'h00; m_age = 0;
    m_ack_a = 1'b0; m_ack_b = 1'b0; m_prev_ack_a = 1'b0; m_prev_ack_b = 1'b0;
    m_irq = 1'b0; m_rd = 32'h0;
  endtask

  task automatic model_step();
    logic       ign_a, ign_b, want_a, want_b, pick_b, wr_res;
    logic [7:0] r;
    m_rd = 32'h0;
    if (read) begin
      case (address)
        2'd0:    m_rd = {23'd0, m_src, (m_ph == 1) ? m_cmd : 8'h00};
        2'd1:    m_rd = {30'd0, m_tflag, (m_ph == 1)};
        2'd3:    m_rd = {31'd0, m_ien};
        default: m_rd = 32'h0;
      endcase
    end
    ign_a = m_prev_ack_a;
    ign_b = m_prev_ack_b;
    m_prev_ack_a = m_ack_a;
    m_prev_ack_b = m_ack_b;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
    if (write && address == 2'd3) begin
      m_ien = writedata[0];
      if (writedata[1]) m_tflag = 1'b0;
    end
    case (m_ph)
      0: begin
        want_a = a_req && !ign_a;
        want_b = b_req && !ign_b;
        if (want_a || want_b) begin
          pick_b   = want_b && (!want_a || !m_last_b);
          m_src    = pick_b;
          m_last_b = pick_b;
          m_cmd    = pick_b ? b_cmd : a_cmd;
          m_age    = 0;
          m_ph     = 1;
        end
      end
      1: begin
        wr_res = write && address == 2'd2;
        if (wr_res || m_age == TO) begin
          r = wr_res ? writedata[7:0] : 8'hFF;
          if (!wr_res) m_tflag = 1'b1;
          if (m_src) begin m_ack_b = 1'b1; m_res_b = r; end
          else       begin m_ack_a = 1'b1; m_res_a = r; end
          m_ph = 2;
        end else begin
          m_age++;
        end
      end
      default: m_ph = 0;
    endcase
    m_irq  = (m_ph == 1) && m_ien;
    m_cmdb = (m_ph == 1) ? m_cmd : 8'h00;
  endtask

  task automatic compare_outputs();
    check_eq("a_ack", a_ack, m_ack_a);
    check_eq("a_result", a_result, m_res_a);
    check_eq("b_ack", b_ack, m_ack_b);
    check_eq("b_result", b_result, m_res_b);
    check_eq("cmd_byte", cmd_byte, m_cmdb);
    check_eq("irq", irq, m_irq);
    check_eq("readdata", readdata, m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic idle_bus();
    read = 1'b0; write = 1'b0; address = 2'd0; writedata = 32'h0;
  endtask

  task automatic nios_write(input logic [1:0] addr, input logic [31:0] data);
    write = 1'b1; address = addr; writedata = data;
    tick();
    write = 1'b0;
  endtask

  task automatic nios_read(input logic [1:0] addr);
    read = 1'b1; address = addr;
    tick();
    read = 1'b0;
  endtask

  // Requester: wait for ack, keep req up for the ack cycle and the one after, then maybe reissue.
  task automatic req_fsm(inout int st, inout logic req, inout logic [7:0] cmd, input logic acked);
    case (st)
      0: if ($urandom_range(2) == 0) begin req = 1'b1; cmd = 8'($urandom); st = 1; end
      1: if (acked) st = 2;
      2: st = 3;
      default: begin
        if ($urandom_range(1) == 0) begin cmd = 8'($urandom); st = 1; end
        else begin req = 1'b0; st = 0; end
      end
    endcase
  endtask

  task automatic nios_rand();
    idle_bus();
    if (m_ph == 1 && $urandom_range(7) == 0) begin
      write = 1'b1; address = 2'd2; writedata = $urandom;
    end else if ($urandom_range(29) == 0) begin
      write = 1'b1; address = 2'($urandom_range(3)); writedata = $urandom;
      writedata[0] = ($urandom_range(3) != 0);
    end
    if ($urandom_range(3) == 0) begin
      read = 1'b1;
      if (!write) address = 2'($urandom_range(3));
    end
  endtask

  int ra_st, rb_st, n;

  initial begin
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0; a_cmd = 8'h00; b_cmd = 8'h00;
    idle_bus();
    #2;
    model_reset();
    compare_outputs();
    tick(); tick();
    reset = 1'b0;

    // Simultaneous requests from reset: A first, B on the idle cycle after A's ack.
    a_req = 1'b1; a_cmd = 8'h10; b_req = 1'b1; b_cmd = 8'h20;
    tick();
    check_eq("t2_first_grant", cmd_byte, 8'h10);
    nios_write(2'd2, 32'h11);
    check_eq("t2_a_ack", a_ack, 1'b1);
    tick();
    tick();
    a_req = 1'b0;
    check_eq("t2_b_grant", cmd_byte, 8'h20);
    nios_read(2'd0);
    check_eq("t2_cmd_reg", readdata, 32'h120);
    nios_write(2'd2, 32'h22);
    check_eq("t2_b_result", b_result, 8'h22);
    tick(); tick();
    b_req = 1'b0;
    tick();

    // Single A command end to end.
    a_req = 1'b1; a_cmd = 8'h21;
    tick();
    check_eq("t1_cmd_byte", cmd_byte, 8'h21);
    check_eq("t1_irq", irq, 1'b1);
    nios_read(2'd0);
    check_eq("t1_cmd_reg", readdata, 32'h021);
    nios_write(2'd2, 32'h05);
    check_eq("t1_ack", a_ack, 1'b1);
    check_eq("t1_result", a_result, 8'h05);
    check_eq("t1_irq_low", irq, 1'b0);
    check_eq("t1_cmd_clr", cmd_byte, 8'h00);
    tick();
    tick();
    check_eq("t1_no_regrant", cmd_byte, 8'h00);
    a_req = 1'b0;
    tick();

    // RESULT while idle is ignored; irq_en masks irq but not pending.
    nios_write(2'd2, 32'h77);
    check_eq("t5_idle_no_ack", {a_ack, b_ack}, 2'b00);
    b_req = 1'b1; b_cmd = 8'h44;
    tick();
    nios_write(2'd3, 32'h0);
    check_eq("t5_irq_masked", irq, 1'b0);
    nios_read(2'd1);
    check_eq("t5_pending", readdata, 32'h1);
    nios_write(2'd3, 32'h1);
    nios_write(2'd2, 32'h99);
    check_eq("t5_b_result", b_result, 8'h99);
    tick(); tick();
    b_req = 1'b0;
    tick();

    // Watchdog abort and flag clear.
    a_req = 1'b1; a_cmd = 8'h33;
    tick();
    n = 0;
    while (!a_ack && n < 40) begin tick(); n++; end
    check_eq("t4_latency", n, 17);
    check_eq("t4_err_result", a_result, 8'hFF);
    tick(); tick();
    a_req = 1'b0;
    nios_read(2'd1);
    check_eq("t4_flag_set", readdata, 32'h2);
    nios_write(2'd3, 32'h3);
    nios_read(2'd1);
    check_eq("t4_flag_clr", readdata, 32'h0);

    // Both hold requests continuously: grants alternate A, B, A.
    do_reset(1);
    a_req = 1'b1; a_cmd = 8'hA0; b_req = 1'b1; b_cmd = 8'hB0;
    tick();
    for (int j = 0; j < 3; j++) begin
      check_eq("t3_grant", cmd_byte, (j % 2 == 1) ? 8'hB0 : 8'hA0);
      nios_write(2'd2, 32'(j));
      tick();
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    nios_write(2'd2, 32'h5);
    tick(); tick(); tick();

    // Reset mid-command, then re-grant of the still-held request.
    a_req = 1'b1; a_cmd = 8'h5A;
    tick();
    check_eq("t6_busy", cmd_byte, 8'h5A);
    do_reset(2);
    check_eq("t6_rst_cmd", cmd_byte, 8'h00);
    check_eq("t6_rst_result", a_result, 8'h00);
    tick();
    check_eq("t6_regrant", cmd_byte, 8'h5A);
    nios_write(2'd2, 32'h6C);
    check_eq("t6_ack", a_ack, 1'b1);
    tick(); tick();
    a_req = 1'b0;
    tick();

    // Randomized traffic.
    ra_st = 0; rb_st = 0;
    for (int i = 0; i < 4000; i++) begin
      req_fsm(ra_st, a_req, a_cmd, m_ack_a);
      req_fsm(rb_st, b_req, b_cmd, m_ack_b);
      nios_rand();
      if ($urandom_range(599) == 0) do_reset(1 + $urandom_range(1));
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
